// File: rtl/rf_write_port_arbiter.sv
// Shares the integer register-file write port between write-back and a buffered long-latency path.
// Optional feature: define RF_WRITE_BYPASS_EN to let LT writes skip an empty FIFO.
module rf_write_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [4:0]                 wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       lt_valid,
    output logic                       lt_ready,
    input  logic [4:0]                 lt_addr,
    input  logic [XLEN-1:0]            lt_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       wb_done,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        WB_PRI,
        LT_PRI
    } state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [4:0]          fifo_addr_q [DEPTH];
    logic [XLEN-1:0]     fifo_data_q [DEPTH];

    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic                wb_done_q, wb_done_d;

    logic                full, empty;
    logic                waw_block;
    logic                wb_grant, head_grant, byp_grant;
    logic                lt_acc, enq;
    logic [31:0]         pend;

    // Pending-register mask: OR of destinations of all live FIFO entries.
    always_comb begin
        logic [PW-1:0] idx;
        pend = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                pend[fifo_addr_q[idx]] = 1'b1;
            end
        end
    end

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        lt_ready   = !reset && !full;
        waw_block  = wb_valid && (wb_addr != 5'd0) && pend[wb_addr];
        wb_ready   = !reset && (state_q == WB_PRI) && !waw_block;
        wb_grant   = wb_valid && wb_ready;
        head_grant = !reset && !empty && !wb_grant;
        lt_acc     = lt_valid && lt_ready;
`ifdef RF_WRITE_BYPASS_EN
        byp_grant  = lt_acc && empty && !wb_grant && (state_q == WB_PRI);
`else
        byp_grant  = 1'b0;
`endif
        enq        = lt_acc && (lt_addr != 5'd0) && !byp_grant;
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        rd_ptr_d   = rd_ptr_q + PW'(head_grant);
        wr_ptr_d   = wr_ptr_q + PW'(enq);
        count_d    = count_q + CW'(enq) - CW'(head_grant);
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_done_d  = wb_grant;

        unique case (1'b1)
            wb_grant: begin
                rf_we_d    = (wb_addr != 5'd0);
                rf_waddr_d = wb_addr;
                rf_wdata_d = wb_data;
            end
            head_grant: begin
                rf_we_d    = (fifo_addr_q[rd_ptr_q] != 5'd0);
                rf_waddr_d = fifo_addr_q[rd_ptr_q];
                rf_wdata_d = fifo_data_q[rd_ptr_q];
            end
            byp_grant: begin
                rf_we_d    = (lt_addr != 5'd0);
                rf_waddr_d = lt_addr;
                rf_wdata_d = lt_data;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase

        if (empty || head_grant) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + SW'(1);
        end

        // LT priority lasts one cycle: the head is always granted while in it.
        if (state_q == LT_PRI) begin
            state_d = WB_PRI;
        end else if (starve_d == SW'(STARVE_LIMIT)) begin
            state_d = LT_PRI;
        end else begin
            state_d = WB_PRI;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WB_PRI;
            starve_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_done_q  <= wb_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q] <= lt_addr;
            fifo_data_q[wr_ptr_q] <= lt_data;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign wb_done    = wb_done_q;
    assign pend_mask  = pend;
    assign fifo_count = count_q;

endmodule
